// File: rtl/accel_pkg.sv
// Shared widths and FSM state encoding for the accelerator regfile readback path.
package accel_pkg;

  localparam int RF_ADDR_W    = 12;
  localparam int STATE_DATA_W = 18;
  localparam int INEX_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } rb_state_t;

endpackage

// File: rtl/rb_fifo2.sv
// Two-entry FIFO; zero-latency head, pushed word visible the cycle after push.
// Push and pop may coincide (also when full); the caller owns overflow avoidance.
module rb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop   = pop && (cnt != 2'd0);
  assign do_push  = push && ((cnt != 2'd2) || do_pop);
  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_readback.sv
// Streams a contiguous regfile window out as {addr,data,last}; first word 2 cycles after start.
// Reads are credit-limited to the 2-entry buffer so out_ready backpressure never drops or repeats words.
module regfile_readback
  import accel_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = STATE_DATA_W,
  parameter int LEN_W  = RF_ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  rb_state_t         state;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  xfer_cnt;

  logic              rd_vld;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_last_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [1:0]        occ;
  logic [1:0]        used;
  entry_t            push_dat;
  entry_t            head_dat;

  assign fifo_pop = out_valid && out_ready;
  assign occ      = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
  // A word leaving the buffer this cycle frees its slot for a read issued now.
  assign used     = occ + {1'b0, rd_vld} - {1'b0, fifo_pop};
  assign rd_en    = (state == RUN) && (issue_cnt != len) && !fifo_full && (used < 2'd2);
  assign rd_addr  = base_addr + issue_cnt[ADDR_W-1:0];

  assign push_dat.addr = rd_addr_q;
  assign push_dat.data = rd_data;
  assign push_dat.last = rd_last_q;

  rb_fifo2 #(
    .W ($bits(entry_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_vld),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_dat.data;
  assign out_addr  = head_dat.addr;
  assign out_last  = head_dat.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      len       <= '0;
      issue_cnt <= '0;
      xfer_cnt  <= '0;
      rd_vld    <= 1'b0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_vld    <= rd_en;
      rd_addr_q <= rd_addr;
      rd_last_q <= (issue_cnt == len - LEN_ONE);
      if (rd_en) begin
        issue_cnt <= issue_cnt + LEN_ONE;
      end
      if (fifo_pop) begin
        xfer_cnt <= xfer_cnt + LEN_ONE;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            base_addr <= start_addr;
            len       <= start_len;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
            busy      <= 1'b1;
            state     <= (start_len == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (fifo_pop && (xfer_cnt == len - LEN_ONE)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          // Zero-length transfers arrive here with busy still high and pulse done one cycle later.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_readback.sv
// Self-checking bench for regfile_readback: regfile model, scoreboard queue and buffer/credit model.
module tb_regfile_readback;

  localparam int AW = 12;
  localparam int DW = 18;
  localparam int LW = 13;
  localparam int EW = AW + DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;

  regfile_readback #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [EW-1:0] exp_q [$];
  int            n_hs   = 0;
  int            n_last = 0;
  int            viol   = 0;
  int            occ    = 0;
  int            infl   = 0;
  logic          hold_vld = 1'b0;
  logic [EW-1:0] hold_val;

  // Scoreboard, hold-stability and buffer/credit model, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      occ = 0; infl = 0; hold_vld = 1'b0;
    end else begin
      if (hold_vld) chk("hold", {out_valid, out_addr, out_data, out_last}, {1'b1, hold_val});
      hold_vld = out_valid && !out_ready;
      hold_val = {out_addr, out_data, out_last};
      if ((occ + infl > 2) || (occ == 2 && rd_en) || (out_valid != (occ != 0))) viol++;
      if (out_valid && out_ready) begin
        n_hs++;
        if (out_last) n_last++;
        if (exp_q.size() == 0) chk("extra_word", {out_addr, out_data, out_last}, '0);
        else chk("word", {out_addr, out_data, out_last}, exp_q.pop_front());
      end
      occ  = occ + infl - ((out_valid && out_ready) ? 1 : 0);
      infl = rd_en ? 1 : 0;
    end
  end

  task automatic do_start(input int a, input int l);
    logic [AW-1:0] ea;
    @(negedge clk);
    start = 1'b1; start_addr = AW'(a); start_len = LW'(l);
    for (int i = 0; i < l; i++) begin
      ea = AW'((a + i) % (1 << AW));
      exp_q.push_back({ea, mem[ea], (i == l - 1)});
    end
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < budget);
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  int            lat, cyc, any, got;
  logic [5:0]    pat;
  logic [2:0]    zb, zd;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);
    rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, rd_en, out_valid, out_last}, 5'b0);
    chk("rst_bus", {rd_addr, out_addr, out_data}, '0);
    rst = 1'b0;

    // Basic read: 4 words from address 0, no backpressure.
    do_start(0, 4);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_rd_en_busy", {rd_en, busy}, 2'b11);
      if (out_valid) begin lat = k; break; end
    end
    chk("t1_latency", lat, 2);
    wait_done("t1", 20, cyc);
    chk("t1_done_delay", cyc, 4);
    chk("t1_busy_at_done", busy, 1'b0);
    start = 1'b1; start_addr = 50; start_len = 2;
    @(posedge clk); #1 start = 1'b0;
    any = 0;
    repeat (5) begin @(negedge clk); if (busy || done || out_valid || rd_en) any++; end
    chk("t1_start_on_done_ignored", any, 0);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_hs", n_hs, 4);
    chk("t1_credit", viol, 0);

    // Backpressure: ready pattern 1,0,0,1,0,1 repeating.
    pat = 6'b101001;
    do_start(100, 6);
    got = 0;
    for (int c = 0; c < 200; c++) begin
      out_ready = pat[c % 6];
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("t2_done_seen", got, 1);
    out_ready = 1'b1;
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_hs", n_hs, 10);
    chk("t2_credit", viol, 0);

    // Wrap-around, then a full-file dump with random backpressure.
    do_start(4094, 4);
    wait_done("t3_wrap", 20, cyc);
    chk("t3_wrap_sb_empty", exp_q.size(), 0);
    n_hs = 0; n_last = 0;
    do_start(7, 4096);
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("t3_full_done_seen", got, 1);
    out_ready = 1'b1;
    chk("t3_full_hs", n_hs, 4096);
    chk("t3_full_last_cnt", n_last, 1);
    chk("t3_full_sb_empty", exp_q.size(), 0);
    chk("t3_credit", viol, 0);

    // Zero length, then a start ignored mid-transfer.
    n_hs = 0;
    do_start(5, 0);
    any = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      zb[k] = busy; zd[k] = done;
      if (rd_en || out_valid) any++;
    end
    chk("t4_zero_busy", zb, 3'b001);
    chk("t4_zero_done", zd, 3'b010);
    chk("t4_zero_no_traffic", any, 0);
    do_start(20, 6);
    repeat (2) @(negedge clk);
    start = 1'b1; start_addr = 50; start_len = 3;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4_ignore", 30, cyc);
    any = 0;
    repeat (8) begin @(negedge clk); if (busy || out_valid || done) any++; end
    chk("t4_ignore_quiet", any, 0);
    chk("t4_hs", n_hs, 6);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Asynchronous reset while the third of eight words is presented.
    do_start(200, 8);
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == AW'(202)) begin got = 1; break; end
    end
    chk("t5_reached_word3", got, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_rst_outs", {busy, done, rd_en, out_valid, out_last}, 5'b0);
    chk("t5_rst_bus", {rd_addr, out_addr, out_data}, '0);
    any = 0;
    repeat (3) begin @(negedge clk); if (done) any++; end
    #2 rst = 1'b0;
    repeat (5) begin @(negedge clk); if (done || busy || out_valid) any++; end
    chk("t5_no_done_after_rst", any, 0);
    n_hs = 0;
    do_start(10, 2);
    wait_done("t5_restart", 20, cyc);
    chk("t5_restart_hs", n_hs, 2);
    chk("t5_sb_empty", exp_q.size(), 0);
    chk("t5_credit", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
